sr_fifo_bank: RTL and testbench

Parametrised multi-channel FIFO bank serving the CPU's push/pop instruction path; the successor to the single fixed 32-bit FIFO. It holds CHANNELS independent first-word-fall-through queues of DEPTH entries each, with one push port and one pop port, each addressed by channel number. It reports per-channel full/empty/occupancy, records sticky overflow/underflow errors, and has an optional same-cycle push-to-pop bypass on empty channels. It sits beside the register file: pushData is driven from rs1 data, and popData feeds the write-back mux.

---
 rtl/sr_fifo_bank_pkg.sv | 13 +
 rtl/sr_fifo_channel.sv | 81 ++++++++
 rtl/sr_fifo_bank.sv | 82 ++++++++
 tb/tb_sr_fifo_bank.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fifo_bank_pkg.sv
// Shared defaults and width helpers for the multi-channel FIFO bank.
package sr_fifo_bank_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_CHANNELS   = 4;

    // A single-channel bank still needs a 1-bit channel select.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/sr_fifo_channel.sv
// One first-word-fall-through queue: circular buffer, occupancy count and sticky error bits.
module sr_fifo_channel
    import sr_fifo_bank_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic                  i_clear_err,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [AW:0]           o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A full queue still takes a push when the same edge frees a slot.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop_ok)  r_rp <= r_rp + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clear_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_push && !w_push_ok) r_overflow  <= 1'b1;
            if (i_pop && w_empty)     r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= i_push_data;
    end

    assign o_head      = r_mem[r_rp];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/sr_fifo_bank.sv
// Bank of independent FWFT queues with one push and one pop port, channel-addressed.
module sr_fifo_bank
    import sr_fifo_bank_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int CHANNELS   = DEF_CHANNELS,
    parameter  int BYPASS     = 0,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = ch_width(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pushEn,
    input  logic [CW-1:0]            pushCh,
    input  logic [DATA_WIDTH-1:0]    pushData,
    input  logic                     popEn,
    input  logic [CW-1:0]            popCh,
    output logic [DATA_WIDTH-1:0]    popData,
    output logic                     popValid,
    output logic [CHANNELS-1:0]      full,
    output logic [CHANNELS-1:0]      empty,
    output logic [CHANNELS*(AW+1)-1:0] count,
    output logic [CHANNELS-1:0]      overflow,
    output logic [CHANNELS-1:0]      underflow,
    input  logic                     clearErr
);

    logic [DATA_WIDTH-1:0] w_head [CHANNELS];
    logic [DATA_WIDTH-1:0] w_sel_head;
    logic                  w_sel_empty;
    logic                  w_bypass;

    always_comb begin
        w_sel_head  = '0;
        w_sel_empty = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (popCh == CW'(i)) begin
                w_sel_head  = w_head[i];
                w_sel_empty = empty[i];
            end
        end
    end

    // Bypassed words go straight to popData and never touch the queue.
    assign w_bypass = (BYPASS != 0) && pushEn && popEn && (pushCh == popCh) && w_sel_empty;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_push;
        logic w_pop;

        assign w_push = pushEn && (pushCh == CW'(g)) && !w_bypass;
        assign w_pop  = popEn && (popCh == CW'(g)) && !w_bypass;

        sr_fifo_channel #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_push     (w_push),
            .i_push_data(pushData),
            .i_pop      (w_pop),
            .i_clear_err(clearErr),
            .o_head     (w_head[g]),
            .o_count    (count[g*(AW+1) +: AW+1]),
            .o_full     (full[g]),
            .o_empty    (empty[g]),
            .o_overflow (overflow[g]),
            .o_underflow(underflow[g])
        );
    end

    always_comb begin
        popData = '0;
        if (w_bypass)          popData = pushData;
        else if (!w_sel_empty) popData = w_sel_head;
    end

    assign popValid = w_bypass || !w_sel_empty;

endmodule

// File: tb/tb_sr_fifo_bank.sv
// Bench for sr_fifo_bank: a BYPASS=0 and a BYPASS=1 instance share stimulus against a queue model.
module tb_sr_fifo_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CH    = 4;
    localparam int AW    = 3;
    localparam int CW    = 2;
    localparam int CNTW  = CH * (AW + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          pushEn;
    logic [CW-1:0] pushCh;
    logic [DW-1:0] pushData;
    logic          popEn;
    logic [CW-1:0] popCh;
    logic          clearErr;

    logic [DW-1:0]   o_data  [2];
    logic            o_valid [2];
    logic [CH-1:0]   o_full  [2];
    logic [CH-1:0]   o_empty [2];
    logic [CNTW-1:0] o_count [2];
    logic [CH-1:0]   o_ovf   [2];
    logic [CH-1:0]   o_unf   [2];

    // model: index 0 = BYPASS off, 1 = BYPASS on
    logic [DW-1:0] mq [2][CH][$];
    logic [CH-1:0] m_ovf [2];
    logic [CH-1:0] m_unf [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sr_fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNELS(CH), .BYPASS(0)) dut (
        .clk(clk), .reset(reset), .pushEn(pushEn), .pushCh(pushCh), .pushData(pushData),
        .popEn(popEn), .popCh(popCh), .popData(o_data[0]), .popValid(o_valid[0]),
        .full(o_full[0]), .empty(o_empty[0]), .count(o_count[0]),
        .overflow(o_ovf[0]), .underflow(o_unf[0]), .clearErr(clearErr)
    );

    sr_fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNELS(CH), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .pushEn(pushEn), .pushCh(pushCh), .pushData(pushData),
        .popEn(popEn), .popCh(popCh), .popData(o_data[1]), .popValid(o_valid[1]),
        .full(o_full[1]), .empty(o_empty[1]), .count(o_count[1]),
        .overflow(o_ovf[1]), .underflow(o_unf[1]), .clearErr(clearErr)
    );

    function automatic logic [AW:0] get_cnt(input logic [CNTW-1:0] c, input int i);
        return c[i*(AW+1) +: AW+1];
    endfunction

    function automatic logic is_bypass(input int m);
        return (m == 1) && pushEn && popEn && (pushCh == popCh) && (mq[m][popCh].size() == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int m);
        if (is_bypass(m)) return pushData;
        if (mq[m][popCh].size() > 0) return mq[m][popCh][0];
        return '0;
    endfunction

    function automatic logic exp_valid(input int m);
        return is_bypass(m) || (mq[m][popCh].size() > 0);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CH; c++) mq[m][c].delete();
            m_ovf[m] = '0;
            m_unf[m] = '0;
        end
    endtask

    task automatic model_commit();
        for (int m = 0; m < 2; m++) begin
            int   sp = mq[m][popCh].size();
            int   su = mq[m][pushCh].size();
            logic pop_ok;
            logic push_ok;
            if (!is_bypass(m)) begin
                pop_ok  = popEn && (sp > 0);
                push_ok = pushEn && ((su < DEPTH) || (pop_ok && (pushCh == popCh)));
                if (pop_ok)  void'(mq[m][popCh].pop_front());
                if (push_ok) mq[m][pushCh].push_back(pushData);
                if (popEn && (sp == 0))  m_unf[m][popCh]  = 1'b1;
                if (pushEn && !push_ok)  m_ovf[m][pushCh] = 1'b1;
            end
            if (clearErr) begin
                m_ovf[m] = '0;
                m_unf[m] = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        pushEn = 1'b0; pushCh = '0; pushData = '0;
        popEn = 1'b0; popCh = '0; clearErr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (o_empty[m] !== 4'hF) $display("FAIL reset_empty[%0d]: got %h exp f", m, o_empty[m]); else n_pass++;
            n_checks++; if (o_full[m] !== 4'h0) $display("FAIL reset_full[%0d]: got %h exp 0", m, o_full[m]); else n_pass++;
            n_checks++; if (o_count[m] !== '0) $display("FAIL reset_count[%0d]: got %h exp 0", m, o_count[m]); else n_pass++;
            n_checks++; if (o_valid[m] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b exp 0", m, o_valid[m]); else n_pass++;
            n_checks++; if (o_data[m] !== '0) $display("FAIL reset_data[%0d]: got %h exp 0", m, o_data[m]); else n_pass++;
            n_checks++; if ((o_ovf[m] | o_unf[m]) !== 4'h0) $display("FAIL reset_err[%0d]: got %h/%h exp 0/0", m, o_ovf[m], o_unf[m]); else n_pass++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fill_overflow();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            pushEn = 1'b1; pushCh = 2'd1; pushData = 32'hA0 + i;
            step();
        end
        pushEn = 1'b0;
        #1;
        n_checks++; if (o_full[0][1] !== 1'b1) $display("FAIL fill_full1: got %b exp 1", o_full[0][1]); else n_pass++;
        n_checks++; if (get_cnt(o_count[0], 1) !== 4'd8) $display("FAIL fill_count1: got %0d exp 8", get_cnt(o_count[0], 1)); else n_pass++;
        pushEn = 1'b1; pushData = 32'hFF;
        step();
        pushEn = 1'b0;
        n_checks++; if (o_ovf[0][1] !== 1'b1) $display("FAIL ovf1: got %b exp 1", o_ovf[0][1]); else n_pass++;
        n_checks++; if (get_cnt(o_count[0], 1) !== 4'd8) $display("FAIL ovf_count1: got %0d exp 8", get_cnt(o_count[0], 1)); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            popEn = 1'b1; popCh = 2'd1;
            #1;
            n_checks++; if (o_data[0] !== 32'hA0 + i) $display("FAIL fill_pop%0d: got %h exp %h", i, o_data[0], 32'hA0 + i); else n_pass++;
            step();
        end
        popEn = 1'b0;
        #1;
        n_checks++; if (o_empty[0][1] !== 1'b1) $display("FAIL fill_empty1: got %b exp 1", o_empty[0][1]); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_q[$];
        idle();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                pushEn = 1'b1; pushCh = 2'd0; pushData = $urandom;
                exp_q.push_back(pushData);
                step();
            end
            pushEn = 1'b0;
            for (int i = 0; i < 5; i++) begin
                logic [DW-1:0] e;
                popEn = 1'b1; popCh = 2'd0;
                #1;
                e = exp_q.pop_front();
                n_checks++; if (o_data[0] !== e) $display("FAIL wrap_r%0d_pop%0d: got %h exp %h", r, i, o_data[0], e); else n_pass++;
                step();
            end
            popEn = 1'b0;
        end
        #1;
        n_checks++; if (get_cnt(o_count[0], 0) !== 4'd0) $display("FAIL wrap_count0: got %0d exp 0", get_cnt(o_count[0], 0)); else n_pass++;
    endtask

    task automatic test_full_pushpop();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            pushEn = 1'b1; pushCh = 2'd2; pushData = 32'h20 + i;
            step();
        end
        pushData = 32'h55; popEn = 1'b1; popCh = 2'd2;
        #1;
        n_checks++; if (o_data[0] !== 32'h20) $display("FAIL fullpp_data: got %h exp 20", o_data[0]); else n_pass++;
        step();
        pushEn = 1'b0; popEn = 1'b0;
        #1;
        n_checks++; if (get_cnt(o_count[0], 2) !== 4'd8) $display("FAIL fullpp_count2: got %0d exp 8", get_cnt(o_count[0], 2)); else n_pass++;
        n_checks++; if (o_ovf[0][2] !== 1'b0) $display("FAIL fullpp_ovf2: got %b exp 0", o_ovf[0][2]); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] e;
            e = (i == DEPTH - 1) ? 32'h55 : 32'h21 + i;
            popEn = 1'b1; popCh = 2'd2;
            #1;
            n_checks++; if (o_data[0] !== e) $display("FAIL fullpp_pop%0d: got %h exp %h", i, o_data[0], e); else n_pass++;
            step();
        end
        popEn = 1'b0;
    endtask

    task automatic test_underflow();
        idle();
        clearErr = 1'b1;
        step();
        clearErr = 1'b0; popEn = 1'b1; popCh = 2'd3;
        #1;
        n_checks++; if (o_data[0] !== '0) $display("FAIL unf_data: got %h exp 0", o_data[0]); else n_pass++;
        n_checks++; if (o_valid[0] !== 1'b0) $display("FAIL unf_valid: got %b exp 0", o_valid[0]); else n_pass++;
        step();
        popEn = 1'b0;
        n_checks++; if (o_unf[0][3] !== 1'b1) $display("FAIL unf_flag3: got %b exp 1", o_unf[0][3]); else n_pass++;
        clearErr = 1'b1;
        step();
        n_checks++; if (o_unf[0] !== 4'h0) $display("FAIL unf_clear: got %h exp 0", o_unf[0]); else n_pass++;
        popEn = 1'b1;
        step();
        idle();
        n_checks++; if (o_unf[0][3] !== 1'b0) $display("FAIL unf_clear_prio: got %b exp 0", o_unf[0][3]); else n_pass++;
    endtask

    task automatic test_bypass();
        idle();
        pushEn = 1'b1; pushCh = 2'd0; pushData = 32'h1234; popEn = 1'b1; popCh = 2'd0;
        #1;
        n_checks++; if (o_data[1] !== 32'h1234) $display("FAIL byp_data: got %h exp 1234", o_data[1]); else n_pass++;
        n_checks++; if (o_valid[1] !== 1'b1) $display("FAIL byp_valid: got %b exp 1", o_valid[1]); else n_pass++;
        n_checks++; if (o_valid[0] !== 1'b0) $display("FAIL nobyp_valid: got %b exp 0", o_valid[0]); else n_pass++;
        step();
        pushEn = 1'b0; popEn = 1'b0;
        #1;
        n_checks++; if (get_cnt(o_count[1], 0) !== 4'd0) $display("FAIL byp_count0: got %0d exp 0", get_cnt(o_count[1], 0)); else n_pass++;
        n_checks++; if (o_unf[1][0] !== 1'b0) $display("FAIL byp_unf0: got %b exp 0", o_unf[1][0]); else n_pass++;
        n_checks++; if (get_cnt(o_count[0], 0) !== 4'd1) $display("FAIL nobyp_count0: got %0d exp 1", get_cnt(o_count[0], 0)); else n_pass++;
        n_checks++; if (o_unf[0][0] !== 1'b1) $display("FAIL nobyp_unf0: got %b exp 1", o_unf[0][0]); else n_pass++;
        popEn = 1'b1;
        #1;
        n_checks++; if (o_data[0] !== 32'h1234) $display("FAIL nobyp_stored: got %h exp 1234", o_data[0]); else n_pass++;
        step();
        popEn = 1'b0; clearErr = 1'b1;
        step();
        clearErr = 1'b0;
    endtask

    task automatic test_random();
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int push_pct = (cyc < 200) ? 75 : 35;
            pushEn   = ($urandom_range(99) < push_pct);
            pushCh   = CW'($urandom_range(CH - 1));
            pushData = $urandom;
            popEn    = ($urandom_range(99) < 100 - push_pct);
            popCh    = ($urandom_range(3) == 0) ? pushCh : CW'($urandom_range(CH - 1));
            clearErr = ($urandom_range(31) == 0);
            #1;
            for (int m = 0; m < 2; m++) begin
                logic [DW-1:0] ed = exp_data(m);
                logic          ev = exp_valid(m);
                n_checks++; if (o_data[m] !== ed) $display("FAIL rnd_data[%0d] c%0d: got %h exp %h", m, cyc, o_data[m], ed); else n_pass++;
                n_checks++; if (o_valid[m] !== ev) $display("FAIL rnd_valid[%0d] c%0d: got %b exp %b", m, cyc, o_valid[m], ev); else n_pass++;
            end
            step();
            for (int m = 0; m < 2; m++) begin
                logic [CH-1:0] ef;
                logic [CH-1:0] ee;
                for (int c = 0; c < CH; c++) begin
                    ef[c] = (mq[m][c].size() == DEPTH);
                    ee[c] = (mq[m][c].size() == 0);
                    n_checks++;
                    if (get_cnt(o_count[m], c) !== (AW+1)'(mq[m][c].size()))
                        $display("FAIL rnd_count[%0d][%0d] c%0d: got %0d exp %0d", m, c, cyc, get_cnt(o_count[m], c), mq[m][c].size());
                    else n_pass++;
                end
                n_checks++; if (o_full[m] !== ef) $display("FAIL rnd_full[%0d] c%0d: got %h exp %h", m, cyc, o_full[m], ef); else n_pass++;
                n_checks++; if (o_empty[m] !== ee) $display("FAIL rnd_empty[%0d] c%0d: got %h exp %h", m, cyc, o_empty[m], ee); else n_pass++;
                n_checks++; if (o_ovf[m] !== m_ovf[m]) $display("FAIL rnd_ovf[%0d] c%0d: got %h exp %h", m, cyc, o_ovf[m], m_ovf[m]); else n_pass++;
                n_checks++; if (o_unf[m] !== m_unf[m]) $display("FAIL rnd_unf[%0d] c%0d: got %h exp %h", m, cyc, o_unf[m], m_unf[m]); else n_pass++;
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            pushEn = 1'b1; pushCh = 2'd1; pushData = $urandom;
            step();
        end
        pushEn = 1'b0; popCh = 2'd1;
        #1;
        n_checks++; if (o_valid[0] !== exp_valid(0)) $display("FAIL premid_valid: got %b exp %b", o_valid[0], exp_valid(0)); else n_pass++;
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (o_empty[m] !== 4'hF) $display("FAIL mid_empty[%0d]: got %h exp f", m, o_empty[m]); else n_pass++;
            n_checks++; if (o_count[m] !== '0) $display("FAIL mid_count[%0d]: got %h exp 0", m, o_count[m]); else n_pass++;
            n_checks++; if (o_valid[m] !== 1'b0) $display("FAIL mid_valid[%0d]: got %b exp 0", m, o_valid[m]); else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_full_pushpop();
        test_underflow();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
